// File: rtl/pc_stream_pkg.sv
// Shared definitions for the pulse-compression streaming blocks: FSM encoding
// and width helpers derived from the table geometry.
package pc_stream_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_STREAM, ST_DRAIN} stream_state_e;

    function automatic int idx_w(input int length);
        return (length > 1) ? $clog2(length) : 1;
    endfunction

    function automatic int bank_w(input int banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

    function automatic int addr_w(input int length, input int banks);
        return (length * banks > 1) ? $clog2(length * banks) : 1;
    endfunction

    function automatic int word_w(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int clamp_bank(input int b, input int banks);
        return (b >= banks) ? banks - 1 : b;
    endfunction

endpackage

// File: rtl/mif_skid_buffer.sv
// Two-entry skid buffer: the head entry drives the outputs, the spare entry
// catches the word already in flight from the registered ROM when the sink stalls.
module mif_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i,
    output logic             last_o
);
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] spare_q, spare_d;
    logic             push, pop;

    assign ready_o = (cnt_q != 2'd2);
    assign valid_o = (cnt_q != 2'd0);
    assign last_o  = (cnt_q == 2'd1);
    assign data_o  = head_q;
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_comb begin
        cnt_d   = cnt_q;
        head_d  = head_q;
        spare_d = spare_q;
        unique case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = data_i;
                end else if (push) begin
                    spare_d = data_i;
                    cnt_d   = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = spare_q;
                    cnt_d  = 2'd1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
        if (flush_i) cnt_d = 2'd0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= 2'd0;
            head_q  <= '0;
            spare_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            spare_q <= spare_d;
        end
    end

endmodule

// File: rtl/mif_stream_reader.sv
// Streams {Re,Im} words from a multi-bank ROM with valid/ready, loop mode and abort.
// Address stage -> registered ROM stage -> skid buffer; the two stages stall together.
module mif_stream_reader
    import pc_stream_pkg::*;
#(
    parameter int    LENGTH     = 800,
    parameter int    DATA_WIDTH = 12,
    parameter int    NUM_BANKS  = 2,
    parameter string MIF_FILE   = "MFImpulseCoeff.mif"
) (
    input  logic                         clock,
    input  logic                         resetN,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loopMode,
    input  logic [bank_w(NUM_BANKS)-1:0] bankSel,
    input  logic                         readyIn,
    output logic                         validOut,
    output logic [DATA_WIDTH-1:0]        outputRe,
    output logic [DATA_WIDTH-1:0]        outputIm,
    output logic [idx_w(LENGTH)-1:0]     indexOut,
    output logic                         busy,
    output logic                         dataFinishedFlag
);
    localparam int IDX_W  = idx_w(LENGTH);
    localparam int ADDR_W = addr_w(LENGTH, NUM_BANKS);
    localparam int WORD_W = word_w(DATA_WIDTH);
    localparam int BUF_W  = IDX_W + WORD_W;
    localparam int DEPTH  = LENGTH * NUM_BANKS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    logic [WORD_W-1:0] rom_mem [DEPTH];

    stream_state_e     state_q, state_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  nidx_q, nidx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  aidx_q, aidx_d;
    logic [1:0]        vld_pipe_q, vld_pipe_d;
    logic [WORD_W-1:0] rdata_q;
    logic [IDX_W-1:0]  ridx_q;

    logic             buf_ready, buf_valid, buf_last;
    logic [BUF_W-1:0] buf_dout;
    logic             s1_adv, s2_adv, pop, done_pulse;

    assign s2_adv = !vld_pipe_q[1] || buf_ready;
    assign s1_adv = !vld_pipe_q[0] || s2_adv;
    assign pop    = buf_valid && readyIn;

    always_comb begin
        state_d    = state_q;
        loop_d     = loop_q;
        base_d     = base_q;
        nidx_d     = nidx_q;
        addr_d     = addr_q;
        aidx_d     = aidx_q;
        vld_pipe_d = vld_pipe_q;
        done_pulse = 1'b0;
        if (s2_adv) vld_pipe_d[1] = vld_pipe_q[0];
        if (s1_adv) vld_pipe_d[0] = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    loop_d        = loopMode;
                    base_d        = ADDR_W'(clamp_bank(int'(bankSel), NUM_BANKS) * LENGTH);
                    addr_d        = base_d;
                    aidx_d        = '0;
                    nidx_d        = IDX_W'(1);
                    vld_pipe_d[0] = 1'b1;
                    state_d       = ST_PRIME;
                end
            end
            ST_PRIME, ST_STREAM: begin
                state_d = ST_STREAM;
                if (s1_adv) begin
                    addr_d        = base_q + ADDR_W'(nidx_q);
                    aidx_d        = nidx_q;
                    vld_pipe_d[0] = 1'b1;
                    nidx_d        = (nidx_q == LAST_IDX) ? '0 : nidx_q + IDX_W'(1);
                    if (!loop_q && nidx_q == LAST_IDX) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Nothing in flight and only the final word left in the buffer.
                if (pop && buf_last && vld_pipe_q == 2'b00) begin
                    done_pulse = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (stop) begin
            state_d    = ST_IDLE;
            vld_pipe_d = 2'b00;
            done_pulse = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            loop_q     <= 1'b0;
            base_q     <= '0;
            nidx_q     <= '0;
            addr_q     <= '0;
            aidx_q     <= '0;
            vld_pipe_q <= 2'b00;
            ridx_q     <= '0;
        end else begin
            state_q    <= state_d;
            loop_q     <= loop_d;
            base_q     <= base_d;
            nidx_q     <= nidx_d;
            addr_q     <= addr_d;
            aidx_q     <= aidx_d;
            vld_pipe_q <= vld_pipe_d;
            if (s2_adv && vld_pipe_q[0]) ridx_q <= aidx_q;
        end
    end

    always_ff @(posedge clock) begin
        if (s2_adv && vld_pipe_q[0]) rdata_q <= rom_mem[addr_q];
    end

    mif_skid_buffer #(.WIDTH(BUF_W)) u_skid (
        .clk_i   (clock),
        .rst_ni  (resetN),
        .flush_i (stop),
        .valid_i (vld_pipe_q[1]),
        .data_i  ({ridx_q, rdata_q}),
        .ready_o (buf_ready),
        .valid_o (buf_valid),
        .data_o  (buf_dout),
        .ready_i (readyIn),
        .last_o  (buf_last)
    );

    assign validOut         = buf_valid;
    assign indexOut         = buf_dout[BUF_W-1 -: IDX_W];
    assign outputRe         = buf_dout[WORD_W-1 -: DATA_WIDTH];
    assign outputIm         = buf_dout[DATA_WIDTH-1:0];
    assign busy             = (state_q != ST_IDLE);
    assign dataFinishedFlag = done_pulse;

endmodule

// File: tb/tb_mif_stream_reader.sv
// Scoreboard bench: stimulus queues expected words, a monitor pops them on each transfer.
module tb_mif_stream_reader;

    typedef struct {
        logic [9:0]  idx;
        logic [11:0] re;
        logic [11:0] im;
        logic        fin;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loopMode = 1'b0;
    logic [0:0]  bankSel = 1'b0;
    logic        readyIn = 1'b1;
    logic        validOut;
    logic [11:0] outputRe;
    logic [11:0] outputIm;
    logic [9:0]  indexOut;
    logic        busy;
    logic        dataFinishedFlag;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    logic        bp_en = 1'b0;
    logic [15:0] lfsr = 16'hACE1;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out = '0;

    always #5 clock = ~clock;

    mif_stream_reader #(
        .LENGTH(800), .DATA_WIDTH(12), .NUM_BANKS(2), .MIF_FILE("")
    ) dut (
        .clock(clock), .resetN(resetN), .start(start), .stop(stop),
        .loopMode(loopMode), .bankSel(bankSel), .readyIn(readyIn),
        .validOut(validOut), .outputRe(outputRe), .outputIm(outputIm),
        .indexOut(indexOut), .busy(busy), .dataFinishedFlag(dataFinishedFlag)
    );

    // Table contents: reference points for bank 0, a simple ramp pattern elsewhere.
    function automatic logic [23:0] rom_word(input int b, input int i);
        int re_v;
        int im_v;
        re_v = ((i * 37 + b * 500 + 11) % 4096) - 2048;
        im_v = ((i * 91 + b * 1300 + 5) % 4096) - 2048;
        if (b == 0) begin
            case (i)
                0:   begin re_v = 1026;  im_v = 1769; end
                1:   begin re_v = 3;     im_v = 2046; end
                2:   begin re_v = -1022; im_v = 1516; end
                798: begin re_v = 1446;  im_v = 624;  end
                799: begin re_v = 1451;  im_v = 1082; end
                default: ;
            endcase
        end
        return {12'(re_v), 12'(im_v)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_run(input int bank, input int first, input int last, input bit lp);
        exp_t        e;
        logic [23:0] w;
        for (int i = first; i <= last; i++) begin
            w     = rom_word(bank, i);
            e.idx = 10'(i);
            e.re  = w[23:12];
            e.im  = w[11:0];
            e.fin = !lp && (i == 799);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int bank, input logic lp, input bit chk_lat);
        @(posedge clock); #1;
        bankSel  = 1'(bank);
        loopMode = lp;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        if (chk_lat) begin
            @(negedge clock);
            chk("lat_busy", 32'(busy), 1);
            chk("lat_c1_valid", 32'(validOut), 0);
            @(negedge clock);
            chk("lat_c2_valid", 32'(validOut), 0);
            @(negedge clock);
            chk("lat_first_valid", 32'(validOut), 1);
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, max);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_xfers(input string name, input int n, input int max);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < max) begin
            @(negedge clock);
            cyc++;
            if (validOut && readyIn) seen++;
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL %s: saw %0d transfers, expected %0d", name, seen, n);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(validOut), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fin"}, 32'(dataFinishedFlag), 0);
        chk({tag, "_idx"}, 32'(indexOut), 0);
        chk({tag, "_re"}, 32'(outputRe), 0);
        chk({tag, "_im"}, 32'(outputIm), 0);
    endtask

    initial begin : ready_drv
        forever begin
            @(posedge clock); #1;
            if (bp_en) begin
                readyIn = lfsr[0];
                lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end else begin
                readyIn = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (prev_stall) begin
                checks++;
                if (!validOut || {indexOut, outputRe, outputIm} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold: got valid %0b word %h, expected valid 1 word %h",
                             validOut, {indexOut, outputRe, outputIm}, prev_out);
                end
            end
            prev_stall = validOut && !readyIn;
            prev_out   = {indexOut, outputRe, outputIm};
            checks++;
            if (validOut && readyIn) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected: got idx %0d, expected no transfer", indexOut);
                end else begin
                    e = exp_q.pop_front();
                    if (indexOut !== e.idx || outputRe !== e.re || outputIm !== e.im ||
                        dataFinishedFlag !== e.fin) begin
                        errors++;
                        $display("FAIL xfer: got idx %0d re %0d im %0d fin %0b, expected idx %0d re %0d im %0d fin %0b",
                                 indexOut, $signed(outputRe), $signed(outputIm), dataFinishedFlag,
                                 e.idx, $signed(e.re), $signed(e.im), e.fin);
                    end
                end
            end else if (dataFinishedFlag !== 1'b0) begin
                errors++;
                $display("FAIL fin_idle: got %0b expected 0", dataFinishedFlag);
            end
        end
    end

    initial begin : stim
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 800; i++)
                dut.rom_mem[11'(b * 800 + i)] = rom_word(b, i);

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_all_zero("rst");
        @(posedge clock); #1;
        resetN = 1'b1;

        // One-shot bank 0, readyIn high, with first-word latency
        push_run(0, 0, 799, 1'b0);
        pulse_start(0, 1'b0, 1'b1);
        wait_idle("oneshot_idle", 2000);
        chk("oneshot_left", 32'(exp_q.size()), 0);

        // Pseudo-random backpressure
        bp_en = 1'b1;
        push_run(0, 0, 799, 1'b0);
        pulse_start(0, 1'b0, 1'b0);
        wait_idle("bp_idle", 6000);
        bp_en = 1'b0;
        chk("bp_left", 32'(exp_q.size()), 0);

        // Loop mode bank 1, three laps then abort
        for (int lap = 0; lap < 3; lap++) push_run(1, 0, 799, 1'b1);
        pulse_start(1, 1'b1, 1'b0);
        wait_xfers("loop_laps", 2400, 4000);
        stop = 1'b1;
        @(posedge clock); #1;
        stop = 1'b0;
        @(negedge clock);
        chk("loop_stop_valid", 32'(validOut), 0);
        chk("loop_stop_busy", 32'(busy), 0);
        chk("loop_left", 32'(exp_q.size()), 0);

        // Stop at index 400, then a fresh run restarts from index 0
        push_run(0, 0, 400, 1'b0);
        pulse_start(0, 1'b0, 1'b0);
        wait_xfers("stop_reach", 401, 1000);
        stop = 1'b1;
        @(posedge clock); #1;
        stop = 1'b0;
        @(negedge clock);
        chk("stop_valid", 32'(validOut), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_fin", 32'(dataFinishedFlag), 0);
        chk("stop_left", 32'(exp_q.size()), 0);
        push_run(0, 0, 799, 1'b0);
        pulse_start(0, 1'b0, 1'b1);
        wait_idle("restart_idle", 2000);
        chk("restart_left", 32'(exp_q.size()), 0);

        // start and stop together: stop wins
        @(posedge clock); #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clock);
        chk("startstop_busy", 32'(busy), 0);
        chk("startstop_valid", 32'(validOut), 0);

        // Reset mid-stream, then a run behaves as from power-up
        push_run(1, 0, 100, 1'b0);
        pulse_start(1, 1'b0, 1'b0);
        wait_xfers("rst_reach", 101, 500);
        resetN = 1'b0;
        @(posedge clock); #1;
        resetN = 1'b1;
        @(negedge clock);
        chk_all_zero("midrst");
        chk("midrst_left", 32'(exp_q.size()), 0);
        push_run(1, 0, 799, 1'b0);
        pulse_start(1, 1'b0, 1'b1);
        wait_idle("postrst_idle", 2000);
        chk("postrst_left", 32'(exp_q.size()), 0);

        // start while busy plus bankSel/loopMode change mid-run: no effect
        push_run(0, 0, 799, 1'b0);
        pulse_start(0, 1'b0, 1'b0);
        wait_xfers("busy_reach", 51, 500);
        start    = 1'b1;
        bankSel  = 1'b1;
        loopMode = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_idle("busy_idle", 2000);
        chk("busy_left", 32'(exp_q.size()), 0);
        bankSel  = 1'b0;
        loopMode = 1'b0;

        repeat (4) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
